fpnew_special_packer: RTL and testbench
=======================================

FPNEW_SPECIAL_PACKER -- requirements
Module: fpnew_special_packer

Interface
REQ-001 Parameter FpFormat, default fpnew_pkg::fp_format_e'(0) (FP32): target format; EXP_BITS/MAN_BITS derived from it.
REQ-002 Parameter BoxWidth, default 64: output register width; SHALL be >= fpnew_pkg::fp_width(FpFormat), elaboration error otherwise.
REQ-003 Parameter TagWidth, default 1: width of sideband tag carried alongside each transaction.
REQ-004 Parameter WIDTH, default fpnew_pkg::fp_width(FpFormat): derived, not to be overridden.
REQ-005 clk_i  input  1  single clock; all state updates on rising edge.
REQ-006 rst_i  input  1  reset, synchronous, active-high.
REQ-007 flush_i  input  1  synchronous kill of all in-flight transactions.
REQ-008 in_valid_i  input  1  request valid.
REQ-009 in_ready_o  output  1  request accepted when in_valid_i && in_ready_o.
REQ-010 class_i  input  3  0 ZERO, 1 MIN_SUBNORMAL, 2 MIN_NORMAL, 3 MAX_NORMAL, 4 INF, 5 QNAN, 6 SNAN, 7 PAYLOAD.
REQ-011 sign_i  input  1  requested sign.
REQ-012 payload_i  input  WIDTH  raw encoding, used only for PAYLOAD.
REQ-013 box_i  input  1  1: upper BoxWidth-WIDTH bits all ones (NaN-boxed); 0: all zeros.
REQ-014 tag_i  input  TagWidth  sideband, passed through unchanged.
REQ-015 out_valid_o  output  1  result valid.
REQ-016 out_ready_i  input  1  result consumed when out_valid_o && out_ready_i.
REQ-017 result_o  output  BoxWidth  boxed encoded value.
REQ-018 tag_o  output  TagWidth  tag of the current result.
REQ-019 busy_o  output  1  high while any pipeline stage holds a valid entry.

Function
REQ-020 Two register stages: S1 holds encoded WIDTH-bit value, tag, box flag; S2 holds boxed result and tag; result_o/tag_o driven from S2 only.
REQ-021 Encoding: ZERO = {sign,0,0}; MIN_SUBNORMAL = {sign,0,1}; MIN_NORMAL = {sign,exp 1,man 0}; MAX_NORMAL = {sign,exp all-ones minus 1,man all-ones}; INF = {sign,exp all-ones,man 0}.
REQ-022 QNAN = canonical {0,exp all-ones,man MSB 1,rest 0}; sign_i ignored.
REQ-023 SNAN = {0,exp all-ones,man MSB 0,man LSB 1,rest 0}; sign_i ignored.
REQ-024 PAYLOAD = payload_i bit-exact, sign_i ignored, no canonicalization.
REQ-025 S2 result = {BoxWidth-WIDTH copies of box flag, encoded value}; when BoxWidth == WIDTH, result = encoded value.
REQ-026 Latency: accepted in cycle N -> out_valid_o in cycle N+2 if S1 and S2 empty at acceptance.
REQ-027 Stage advance: S2 loads when S1 valid and (S2 empty or out_ready_i); S1 loads when in_valid_i and (S1 empty or S1 advancing).
REQ-028 in_ready_o = !S1.valid || S1 advancing; combinational from out_ready_i; no combinational path from in_valid_i to in_ready_o.
REQ-029 Full throughput: one transaction per cycle while out_ready_i held high.
REQ-030 Backpressure: while out_valid_o && !out_ready_i, result_o and tag_o SHALL hold stable; at most 2 transactions held; third stalls via in_ready_o = 0.
REQ-031 Ordering: results emerge in acceptance order; no drop, no duplication.
REQ-032 flush_i: both stage valids cleared at next edge; a request presented in the flush cycle is not accepted (in_ready_o = 0 during flush_i).
REQ-033 busy_o = S1.valid || S2.valid.

Reset
REQ-034 rst_i high at a rising edge: S1.valid = S2.valid = 0, out_valid_o = 0, busy_o = 0, result_o = 0, tag_o = 0.
REQ-035 in_ready_o = 0 while rst_i high; reset dominates flush_i and a simultaneous handshake; in-flight data discarded.
REQ-036 Data registers other than result/tag need no reset.

Verification
REQ-037 FP32, BoxWidth 64: ZERO sign 1 box 1 -> 0xFFFFFFFF80000000 two cycles later; INF sign 1 box 0 -> 0x00000000FF800000.
REQ-038 QNAN sign 1 box 1 -> 0xFFFFFFFF7FC00000; SNAN -> low 32 bits 0x7F800001; MAX_NORMAL sign 0 -> 0x7F7FFFFF; MIN_NORMAL -> 0x00800000; MIN_SUBNORMAL -> 0x00000001.
REQ-039 Streaming: 8 back-to-back requests, tags 0..7, out_ready_i = 1 -> 8 results on 8 consecutive cycles, tags in order.
REQ-040 Backpressure: out_ready_i = 0 for 5 cycles with in_valid_i = 1 -> exactly 2 accepted, in_ready_o = 0 after, result_o stable; release -> remaining results in order, none lost.
REQ-041 flush_i with both stages full -> out_valid_o = 0 and busy_o = 0 next cycle; subsequent request returns normally after 2 cycles.
REQ-042 rst_i asserted mid-stream -> all outputs at reset values next cycle; random class/sign/box stimulus decoded back into sign/exponent/mantissa fields matches REQ-021..025.

Source files
------------

// File: rtl/fpnew_special_packer_if.sv
// Request/response bundle for fpnew_special_packer: request handshake, flush,
// boxed result handshake and occupancy flag.
interface fpnew_special_packer_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned BOX_WIDTH = 64,
  parameter int unsigned TAG_WIDTH = 1
);
  logic                 flush_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [2:0]           class_i;
  logic                 sign_i;
  logic [WIDTH-1:0]     payload_i;
  logic                 box_i;
  logic [TAG_WIDTH-1:0] tag_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [BOX_WIDTH-1:0] result_o;
  logic [TAG_WIDTH-1:0] tag_o;
  logic                 busy_o;

  modport master (
    output flush_i, in_valid_i, class_i, sign_i, payload_i, box_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, tag_o, busy_o
  );

  modport slave (
    input  flush_i, in_valid_i, class_i, sign_i, payload_i, box_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, tag_o, busy_o
  );
endinterface

// File: rtl/fpnew_special_packer.sv
// Two-stage pipeline that encodes special FP constants (zero, extremes, inf,
// NaNs, raw payload) and NaN-boxes / zero-extends them to BoxWidth bits.
package fpnew_pkg;
  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [2:0] {
    CLS_ZERO          = 3'd0,
    CLS_MIN_SUBNORMAL = 3'd1,
    CLS_MIN_NORMAL    = 3'd2,
    CLS_MAX_NORMAL    = 3'd3,
    CLS_INF           = 3'd4,
    CLS_QNAN          = 3'd5,
    CLS_SNAN          = 3'd6,
    CLS_PAYLOAD       = 3'd7
  } special_class_e;

  function automatic int unsigned exp_bits(fp_format_e fmt);
    case (fmt)
      FP64:      return 11;
      FP16, FP8: return 5;
      default:   return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(fp_format_e fmt);
    case (fmt)
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 23;
    endcase
  endfunction

  function automatic int unsigned fp_width(fp_format_e fmt);
    return 1 + exp_bits(fmt) + man_bits(fmt);
  endfunction
endpackage

module fpnew_special_packer #(
  parameter fpnew_pkg::fp_format_e FpFormat = fpnew_pkg::fp_format_e'(0),
  parameter int unsigned BoxWidth = 64,
  parameter int unsigned TagWidth = 1,
  parameter int unsigned WIDTH    = fpnew_pkg::fp_width(FpFormat)
) (
  input logic clk_i,
  input logic rst_i,
  fpnew_special_packer_if.slave bus
);
  localparam int unsigned EXP_BITS = fpnew_pkg::exp_bits(FpFormat);
  localparam int unsigned MAN_BITS = fpnew_pkg::man_bits(FpFormat);

  if (BoxWidth < WIDTH) begin : g_bad_box
    $error("fpnew_special_packer: BoxWidth must be >= format width");
  end

  logic                s1_valid;
  logic [WIDTH-1:0]    s1_value;
  logic [TagWidth-1:0] s1_tag;
  logic                s1_box;
  logic                s2_valid;
  logic [BoxWidth-1:0] s2_result;
  logic [TagWidth-1:0] s2_tag;

  logic                s1_load;
  logic                s2_load;
  logic                in_ready;
  logic                sign_f;
  logic [EXP_BITS-1:0] exp_f;
  logic [MAN_BITS-1:0] man_f;
  logic [WIDTH-1:0]    enc_value;
  logic [BoxWidth-1:0] boxed;

  assign s2_load  = s1_valid && (!s2_valid || bus.out_ready_i);
  assign in_ready = !rst_i && !bus.flush_i && (!s1_valid || s2_load);
  assign s1_load  = bus.in_valid_i && in_ready;

  always_comb begin
    sign_f = bus.sign_i;
    exp_f  = '0;
    man_f  = '0;
    case (bus.class_i)
      fpnew_pkg::CLS_MIN_SUBNORMAL: man_f = MAN_BITS'(1);
      fpnew_pkg::CLS_MIN_NORMAL:    exp_f = EXP_BITS'(1);
      fpnew_pkg::CLS_MAX_NORMAL: begin
        exp_f = {{(EXP_BITS-1){1'b1}}, 1'b0};
        man_f = '1;
      end
      fpnew_pkg::CLS_INF:           exp_f = '1;
      fpnew_pkg::CLS_QNAN: begin
        sign_f = 1'b0;
        exp_f  = '1;
        man_f  = {1'b1, {(MAN_BITS-1){1'b0}}};
      end
      fpnew_pkg::CLS_SNAN: begin
        sign_f = 1'b0;
        exp_f  = '1;
        man_f  = MAN_BITS'(1);
      end
      default: ;
    endcase
    enc_value = (bus.class_i == fpnew_pkg::CLS_PAYLOAD) ? bus.payload_i
                                                        : {sign_f, exp_f, man_f};
  end

  if (BoxWidth > WIDTH) begin : g_box
    assign boxed = {{(BoxWidth-WIDTH){s1_box}}, s1_value};
  end else begin : g_nobox
    assign boxed = s1_value;
  end

  // Only valids and the visible result/tag are reset; S1 payload is don't-care.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_tag    <= '0;
    end else if (bus.flush_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= s1_load || (s1_valid && !s2_load);
      s2_valid <= s2_load || (s2_valid && !bus.out_ready_i);
      if (s2_load) begin
        s2_result <= boxed;
        s2_tag    <= s1_tag;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (s1_load) begin
      s1_value <= enc_value;
      s1_tag   <= bus.tag_i;
      s1_box   <= bus.box_i;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = s2_valid;
  assign bus.result_o    = s2_result;
  assign bus.tag_o       = s2_tag;
  assign bus.busy_o      = s1_valid || s2_valid;
endmodule

// File: tb/tb_fpnew_special_packer.sv
// Randomised and directed bench for fpnew_special_packer (FP32, 64-bit box)
// checked every cycle against an in-order queue model with latency tracking.
module tb_fpnew_special_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpnew_special_packer_if #(.WIDTH(32), .BOX_WIDTH(64), .TAG_WIDTH(4)) bus ();

  fpnew_special_packer #(.TagWidth(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [63:0] res;
    logic [3:0]  tag;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   out_cycles[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   n_acc    = 0;
  bit   armed    = 0;
  bit   after_reset = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    else n_pass++;
  endtask

  // Field-level FP32 construction: value = sign*2^31 + exp*2^23 + man.
  function automatic logic [63:0] model_result(input int cls, input bit s,
                                               input logic [31:0] p, input bit b);
    longint unsigned e = 0, m = 0, v;
    bit sg = s;
    case (cls)
      1: m = 1;
      2: e = 1;
      3: begin e = 254; m = (64'd1 << 23) - 1; end
      4: e = 255;
      5: begin sg = 0; e = 255; m = 64'd1 << 22; end
      6: begin sg = 0; e = 255; m = 1; end
      default: ;
    endcase
    v = (cls == 7) ? longint'(p) : ((longint'(sg) << 31) + (e << 23) + m);
    return (b ? 64'hFFFF_FFFF_0000_0000 : 64'h0) | v;
  endfunction

  always @(negedge clk) begin
    bit exp_ready, exp_valid, fire_in, fire_out;
    if (armed) begin
      exp_ready = !rst && !bus.flush_i && (q.size() < 2 || bus.out_ready_i);
      exp_valid = q.size() > 0 && (cyc - q[0].acc >= 2);
      check("in_ready", 64'(bus.in_ready_o), 64'(exp_ready));
      check("out_valid", 64'(bus.out_valid_o), 64'(exp_valid));
      check("busy", 64'(bus.busy_o), 64'(q.size() > 0));
      if (exp_valid) begin
        check("result", bus.result_o, q[0].res);
        check("tag", 64'(bus.tag_o), 64'(q[0].tag));
      end
      if (after_reset) begin
        check("reset_result", bus.result_o, 64'h0);
        check("reset_tag", 64'(bus.tag_o), 64'h0);
      end
      fire_in  = bus.in_valid_i && exp_ready;
      fire_out = exp_valid && bus.out_ready_i;
      if (rst) begin
        q.delete();
        after_reset = 1;
      end else if (bus.flush_i) begin
        q.delete();
      end else begin
        if (fire_out) begin
          void'(q.pop_front());
          out_cycles.push_back(cyc);
        end
        if (fire_in) begin
          q.push_back('{model_result(int'(bus.class_i), bus.sign_i, bus.payload_i, bus.box_i),
                        bus.tag_i, cyc});
          n_acc++;
          after_reset = 0;
        end
      end
    end
    if (rst) armed = 1;
    cyc++;
  end

  task automatic send(input int c, input bit s, input logic [31:0] p, input bit b,
                      input logic [3:0] t);
    int k = 0;
    bus.in_valid_i = 1; bus.class_i = 3'(c); bus.sign_i = s;
    bus.payload_i = p;  bus.box_i = b;       bus.tag_i = t;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.in_ready_o && k < 100);
    check("send_accept", 64'(bus.in_ready_o), 64'h1);
    @(posedge clk); #1;
    bus.in_valid_i = 0;
  endtask

  task automatic drain();
    int k = 0;
    bus.in_valid_i = 0; bus.out_ready_i = 1; bus.flush_i = 0;
    while (q.size() > 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_empty", 64'(q.size()), 64'h0);
  endtask

  initial begin
    bus.flush_i = 0; bus.in_valid_i = 0; bus.class_i = 0; bus.sign_i = 0;
    bus.payload_i = '0; bus.box_i = 0; bus.tag_i = 0; bus.out_ready_i = 1;

    check("pin_zero", model_result(0, 1, 0, 1), 64'hFFFF_FFFF_8000_0000);
    check("pin_inf", model_result(4, 1, 0, 0), 64'h0000_0000_FF80_0000);
    check("pin_qnan", model_result(5, 1, 0, 1), 64'hFFFF_FFFF_7FC0_0000);
    check("pin_snan", model_result(6, 1, 0, 0), 64'h0000_0000_7F80_0001);
    check("pin_max", model_result(3, 0, 0, 0), 64'h0000_0000_7F7F_FFFF);
    check("pin_minn", model_result(2, 0, 0, 0), 64'h0000_0000_0080_0000);
    check("pin_mins", model_result(1, 0, 0, 0), 64'h0000_0000_0000_0001);

    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (2) @(posedge clk); #1;

    // Each class in isolation, idle pipeline between requests.
    send(0, 1, 32'h0, 1, 4'd1);            repeat (3) @(posedge clk); #1;
    send(4, 1, 32'h0, 0, 4'd2);            repeat (3) @(posedge clk); #1;
    send(5, 1, 32'h0, 1, 4'd3);            repeat (3) @(posedge clk); #1;
    send(6, 1, 32'h0, 0, 4'd4);            repeat (3) @(posedge clk); #1;
    send(3, 0, 32'h0, 0, 4'd5);            repeat (3) @(posedge clk); #1;
    send(2, 0, 32'h0, 0, 4'd6);            repeat (3) @(posedge clk); #1;
    send(1, 0, 32'h0, 1, 4'd7);            repeat (3) @(posedge clk); #1;
    send(7, 1, 32'h7FC0_1234, 1, 4'd8);    repeat (3) @(posedge clk); #1;

    // Back-to-back stream: results must appear on consecutive cycles.
    out_cycles.delete();
    for (int i = 0; i < 8; i++) send(i, i[0], $urandom, i[1], 4'(i));
    drain();
    check("stream_count", 64'(out_cycles.size()), 64'd8);
    if (out_cycles.size() == 8)
      check("stream_span", 64'(out_cycles[7] - out_cycles[0]), 64'd7);

    // Backpressure: only two requests fit while the sink stalls.
    bus.out_ready_i = 0;
    n_acc = 0;
    bus.in_valid_i = 1; bus.class_i = 3'd3; bus.sign_i = 1; bus.box_i = 1; bus.tag_i = 4'd9;
    repeat (5) @(posedge clk);
    #1;
    check("bp_accepted", 64'(n_acc), 64'd2);
    check("bp_in_ready", 64'(bus.in_ready_o), 64'h0);
    bus.in_valid_i = 0;
    drain();

    // Flush with both stages occupied, then a normal request afterwards.
    bus.out_ready_i = 0;
    send(4, 0, 32'h0, 1, 4'd10);
    send(0, 0, 32'h0, 1, 4'd11);
    bus.flush_i = 1; bus.in_valid_i = 1;
    @(posedge clk); #1;
    bus.flush_i = 0; bus.in_valid_i = 0; bus.out_ready_i = 1;
    @(negedge clk);
    check("flush_empty", 64'(q.size()), 64'h0);
    @(posedge clk); #1;
    send(5, 0, 32'h0, 0, 4'd12);
    drain();

    // Random traffic with occasional flush and a mid-stream reset.
    for (int i = 0; i < 600; i++) begin
      bus.in_valid_i  = ($urandom_range(0, 9) < 7);
      bus.class_i     = 3'($urandom_range(0, 7));
      bus.sign_i      = 1'($urandom);
      bus.box_i       = 1'($urandom);
      bus.payload_i   = $urandom;
      bus.tag_i       = 4'($urandom);
      bus.out_ready_i = ($urandom_range(0, 3) != 0);
      bus.flush_i     = ($urandom_range(0, 39) == 0);
      rst             = (i == 300);
      @(posedge clk); #1;
    end
    rst = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
